dcache_wb_ctrl: RTL and testbench

// - Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and the

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_line_store.sv | 67 ++++++
 rtl/dcache_wb_ctrl.sv | 146 ++++++++++++++
 tb/tb_dcache_wb_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Holds the FSM state encoding and the word-merge helper used on store hits.
package dcache_pkg;

  localparam int LINE_BITS      = 256;
  localparam int OFFSET_W       = 5;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 32;
  localparam int WORD_SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILLED  = 2'd3
  } state_e;

  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0]  line,
    input logic [WORD_SEL_W-1:0] sel,
    input logic [WORD_W-1:0]     word
  );
    logic [LINE_BITS-1:0] merged;
    merged = line;
    merged[sel*WORD_W +: WORD_W] = word;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage with a combinational read port.
// A full-line write (refill) takes priority over a word write (store hit).
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - INDEX_W - OFFSET_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic [INDEX_W-1:0]    wr_idx_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_data_i,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_BITS-1:0]  line_data_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (line_we_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = 1'b0;
      tag_d[wr_idx_i]   = line_tag_i;
      data_d[wr_idx_i]  = line_data_i;
    end else if (word_we_i) begin
      dirty_d[wr_idx_i] = 1'b1;
      data_d[wr_idx_i]  = merge_word(data_q[wr_idx_i], word_sel_i, word_data_i);
    end
  end

  // Only the control bits are reset; tag/data are meaningless while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller: zero-stall
// word hits, miss FSM that writes back a dirty victim and refills the line.
module dcache_wb_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_wr_q, mem_wr_d;

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_W-1:0]    addr_idx;
  logic [WORD_SEL_W-1:0] addr_word;
  logic                  req, hit, is_idle;
  logic [INDEX_W-1:0]    line_idx;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  unused_addr_lsbs;

  assign addr_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx         = p1_addr_i[OFFSET_W +: INDEX_W];
  assign addr_word        = p1_addr_i[OFFSET_W-1:2];
  assign unused_addr_lsbs = ^p1_addr_i[1:0];

  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign is_idle = (state_q == IDLE);
  // The miss line is latched so a dropped request cannot redirect the refill.
  assign line_idx = is_idle ? addr_idx : miss_idx_q;
  assign hit      = is_idle && rd_valid && (rd_tag == addr_tag);

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (line_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_idx_i    (line_idx),
    .word_we_i   (p1_MemWrite_i && hit),
    .word_sel_i  (addr_word),
    .word_data_i (p1_data_i),
    .line_we_i   ((state_q == ALLOCATE) && mem_ack_i),
    .line_tag_i  (miss_tag_q),
    .line_data_i (mem_data_i)
  );

  assign p1_stall_o = req && !hit;
  assign p1_data_o  = (p1_MemRead_i && !p1_MemWrite_i && hit)
                      ? rd_line[addr_word*WORD_W +: WORD_W] : '0;

  always_comb begin
    state_d    = state_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss_idx_d = addr_idx;
          miss_tag_d = addr_tag;
          mem_en_d   = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d    = WRITEBACK;
            mem_wr_d   = 1'b1;
            mem_addr_d = {rd_tag, addr_idx, {OFFSET_W{1'b0}}};
          end else begin
            state_d    = ALLOCATE;
            mem_wr_d   = 1'b0;
            mem_addr_d = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d    = ALLOCATE;
          mem_wr_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_d    = REFILLED;
          mem_en_d   = 1'b0;
          mem_wr_d   = 1'b0;
          mem_addr_d = '0;
        end
      end
      REFILLED: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
    end
    miss_idx_q <= miss_idx_d;
    miss_tag_q <= miss_tag_d;
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_data_o   = (state_q == WRITEBACK) ? rd_line : '0;

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized accesses against a cache/shadow-memory reference model.
module tb_dcache_wb_ctrl;
  import dcache_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LAT    = 10;

  logic                 clk, rst;
  logic [ADDR_W-1:0]    p1_addr;
  logic [31:0]          p1_wdata, p1_data_o;
  logic                 p1_rd, p1_wr, p1_stall_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o, mem_data_i;
  logic                 mem_enable_o, mem_write_o, mem_ack_i;

  dcache_wb_ctrl #(.NUM_LINES(16), .ADDR_W(ADDR_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: 64 lines, word at byte address a preloaded with a.
  logic [LINE_BITS-1:0] mem [64];
  logic                 ack_q;
  logic [LINE_BITS-1:0] rdata_q;
  int                   cnt;
  int                   n_rd = 0, n_wr = 0, viol = 0;
  logic [31:0]          last_rd_addr = '0, last_wr_addr = '0;
  logic [LINE_BITS-1:0] last_wr_data = '0;

  assign mem_ack_i  = ack_q;
  assign mem_data_i = ack_q ? rdata_q : {8{32'h5A5A_A5A5}};

  always @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      cnt   <= 0;
    end else if (ack_q) begin
      ack_q <= 1'b0;
      cnt   <= 0;
      if (mem_write_o) begin
        mem[mem_addr_o[10:5]] <= mem_data_o;
        n_wr                  <= n_wr + 1;
        last_wr_addr          <= mem_addr_o;
        last_wr_data          <= mem_data_o;
      end else begin
        n_rd         <= n_rd + 1;
        last_rd_addr <= mem_addr_o;
      end
    end else if (mem_enable_o) begin
      if (cnt == LAT - 2) begin
        ack_q   <= 1'b1;
        rdata_q <= mem[mem_addr_o[10:5]];
      end
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  // Continuous protocol observations, judged once at the end.
  always @(negedge clk) begin
    if (!rst)
      viol <= viol + ((mem_addr_o[4:0] != 5'd0) ? 1 : 0)
                   + ((!(mem_enable_o && mem_write_o) && mem_data_o != '0) ? 1 : 0)
                   + (((p1_stall_o || !p1_rd || p1_wr) && p1_data_o != 32'd0) ? 1 : 0);
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; p1_rd = 1'b0; p1_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int stalls, output logic [31:0] dout);
    @(posedge clk); #1;
    p1_rd = rd; p1_wr = wr; p1_addr = a; p1_wdata = d;
    stalls = 0;
    @(negedge clk);
    while (p1_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    dout = p1_data_o;
    @(posedge clk); #1;
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic wait_enable(input string nm);
    int n;
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, (n < 50)}, 32'd1);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          exp_stall;
    logic [31:0] exp_data;
    int          exp_nrd, exp_nwr;
    logic [31:0] exp_rd_addr;
  } vec_t;

  vec_t        vecs [8];
  int          st;
  logic [31:0] dout;

  // Reference model for the random phase: cache bookkeeping plus a word shadow.
  int          m_valid [16], m_dirty [16], m_tag [16];
  logic [31:0] sh [512];

  initial begin
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 8; w++)
        mem[l][w*32 +: 32] = 32'(l*32 + w*4);
    rst = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,         12, 32'h40,       1, 0, 32'h40};
    vecs[1] = '{1'b1, 1'b0, 32'h44,  32'h0,         0,  32'h44,       1, 0, 32'h40};
    vecs[2] = '{1'b0, 1'b1, 32'h48,  32'hDEADBEEF,  0,  32'h0,        1, 0, 32'h40};
    vecs[3] = '{1'b1, 1'b0, 32'h48,  32'h0,         0,  32'hDEADBEEF, 1, 0, 32'h40};
    vecs[4] = '{1'b1, 1'b0, 32'h248, 32'h0,         22, 32'h248,      2, 1, 32'h240};
    vecs[5] = '{1'b1, 1'b1, 32'h44,  32'h12345678,  12, 32'h0,        3, 1, 32'h40};
    vecs[6] = '{1'b1, 1'b0, 32'h44,  32'h0,         0,  32'h12345678, 3, 1, 32'h40};
    vecs[7] = '{1'b1, 1'b0, 32'h48,  32'h0,         0,  32'hDEADBEEF, 3, 1, 32'h40};

    do_reset();
    @(negedge clk);
    chk("rst_stall",   {31'd0, p1_stall_o},   32'd0);
    chk("rst_data",    p1_data_o,             32'd0);
    chk("rst_enable",  {31'd0, mem_enable_o}, 32'd0);
    chk("rst_write",   {31'd0, mem_write_o},  32'd0);
    chk("rst_addr",    mem_addr_o,            32'd0);

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, dout);
      chk($sformatf("vec%0d_stall", i),   32'(st),      32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_data", i),    dout,         vecs[i].exp_data);
      chk($sformatf("vec%0d_nrd", i),     32'(n_rd),    32'(vecs[i].exp_nrd));
      chk($sformatf("vec%0d_nwr", i),     32'(n_wr),    32'(vecs[i].exp_nwr));
      chk($sformatf("vec%0d_rdaddr", i),  last_rd_addr, vecs[i].exp_rd_addr);
    end
    chk("wb_addr",  last_wr_addr,          32'h40);
    chk("wb_word0", last_wr_data[31:0],    32'h40);
    chk("wb_word1", last_wr_data[63:32],   32'h44);
    chk("wb_word2", last_wr_data[95:64],   32'hDEADBEEF);

    // Reset pulsed during ALLOCATE: request aborted, line stays invalid.
    do_reset();
    @(posedge clk); #1;
    p1_rd = 1'b1; p1_addr = 32'h40;
    wait_enable("rstmid_alloc_seen");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; p1_rd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_enable", {31'd0, mem_enable_o}, 32'd0);
    chk("rstmid_stall",  {31'd0, p1_stall_o},   32'd0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, st, dout);
    chk("rstmid_reread_stall", 32'(st), 32'd12);
    chk("rstmid_reread_data",  dout,    32'h40);

    // Request dropped mid-miss: refill still completes, later access hits.
    @(posedge clk); #1;
    p1_rd = 1'b1; p1_addr = 32'h460;
    wait_enable("drop_alloc_seen");
    repeat (2) @(posedge clk);
    #1 p1_rd = 1'b0; p1_addr = 32'h80;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drop_enable_idle", {31'd0, mem_enable_o}, 32'd0);
    do_access(1'b1, 1'b0, 32'h464, 32'h0, st, dout);
    chk("drop_hit_stall", 32'(st), 32'd0);
    chk("drop_hit_data",  dout,    32'h464);

    // Randomized phase starting from an empty cache.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0;
    end
    for (int i = 0; i < 512; i++) sh[i] = mem[i/8][(i%8)*32 +: 32];
    for (int n = 0; n < 300; n++) begin
      int          tg, ix, wd, op, exp_st;
      logic        rd, wr, hit;
      logic [31:0] a, d, exp_d;
      tg = int'($urandom_range(0, 3));
      ix = int'($urandom_range(0, 15));
      wd = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 3));
      a  = 32'(tg*512 + ix*32 + wd*4);
      d  = $urandom;
      rd = (op != 2);
      wr = (op >= 2);
      hit    = (m_valid[ix] != 0) && (m_tag[ix] == tg);
      exp_st = hit ? 0 : ((m_valid[ix] != 0 && m_dirty[ix] != 0) ? 2*LAT + 2 : LAT + 2);
      exp_d  = (rd && !wr) ? sh[a[10:2]] : 32'd0;
      do_access(rd, wr, a, d, st, dout);
      chk($sformatf("rnd%0d_stall@%h", n, a), 32'(st), 32'(exp_st));
      chk($sformatf("rnd%0d_data@%h", n, a),  dout,    exp_d);
      if (!hit) begin
        m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0;
      end
      if (wr) begin
        m_dirty[ix] = 1;
        sh[a[10:2]] = d;
      end
    end

    @(negedge clk);
    chk("protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
